// File: rtl/lock_pkg.sv
// lock_pkg: state encoding, UI timing defaults and width helper shared by the lock UI blocks.
package lock_pkg;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;
    localparam int TICK_DIV_100MHZ = 250000;
    localparam int SHOW_TICKS = 400;
    typedef enum logic {IDLE = ST_IDLE, HOLD = ST_HOLD} state_e;
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if: trigger request and display outputs of the pulse stretcher.
interface pulse_stretcher_if;
    logic trig;
    logic blink_mode;
    logic led_out;
    logic busy;
    logic done;
    modport master (output trig, blink_mode, input led_out, busy, done);
    modport slave (input trig, blink_mode, output led_out, busy, done);
endinterface

// File: rtl/pulse_stretcher_tick_gen.sv
// tick_gen: clearable prescaler emitting a one-cycle tick every DIV clk cycles.
module tick_gen import lock_pkg::*; #(
    parameter int DIV = TICK_DIV_100MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int PW = cw(DIV);
    logic [PW-1:0] pre_q, pre_d;
    assign tick = pre_q == PW'(DIV - 1);
    always_comb pre_d = (clr || tick) ? '0 : PW'(pre_q + 1'b1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches a one-cycle event into a solid or blinking HOLD_TICKS*DIV display.
// Define PULSE_STRETCHER_RETRIGGER_EN to let trig restart a display in progress.
module pulse_stretcher import lock_pkg::*; #(
    parameter int DIV        = TICK_DIV_100MHZ,
    parameter int HOLD_TICKS = SHOW_TICKS,
    parameter int BLINK_HALF = 50
) (
    input logic clk,
    input logic rst_n,
    pulse_stretcher_if.slave bus
);
    localparam int HW = cw(HOLD_TICKS);
    localparam int BW = cw(BLINK_HALF);
    state_e state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] ph_q, ph_d;
    logic led_q, led_d, done_q, done_d, mode_q, mode_d;
    logic start, tick, clr, ph_wrap;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    assign start = bus.trig;
`else
    assign start = bus.trig && state_q == IDLE;
`endif
    // prescaler is held at zero while idle so every display starts on a full tick
    assign clr = start || state_q == IDLE;
    assign ph_wrap = ph_q == BW'(BLINK_HALF - 1);
    tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst_n(rst_n), .clr(clr), .tick(tick));
    always_comb begin
        state_d = state_q;
        hold_d = hold_q;
        ph_d = ph_q;
        led_d = led_q;
        mode_d = mode_q;
        done_d = 1'b0;
        if (start) begin
            state_d = HOLD;
            hold_d = '0;
            ph_d = '0;
            led_d = 1'b1;
            mode_d = bus.blink_mode;
        end else if (state_q == HOLD && tick) begin
            if (hold_q == HW'(HOLD_TICKS - 1)) begin
                state_d = IDLE;
                hold_d = '0;
                ph_d = '0;
                led_d = 1'b0;
                done_d = 1'b1;
            end else begin
                hold_d = HW'(hold_q + 1'b1);
                ph_d = ph_wrap ? '0 : BW'(ph_q + 1'b1);
                led_d = (mode_q && ph_wrap) ? ~led_q : led_q;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q <= '0;
            ph_q <= '0;
            led_q <= 1'b0;
            done_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q <= hold_d;
            ph_q <= ph_d;
            led_q <= led_d;
            done_q <= done_d;
            mode_q <= mode_d;
        end
    assign bus.led_out = led_q;
    assign bus.busy = state_q == HOLD;
    assign bus.done = done_q;
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: vector tables, corner sequences and random traffic against a cycle-count model.
module tb_pulse_stretcher;
    localparam int DIV = 4, HT = 3, BH = 1, T = DIV * HT;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif
    typedef struct {bit trig, blink, led, busy, done;} vec_t;
    logic clk = 1'b0, rst_n = 1'b0;
    int errors = 0, checks = 0;
    bit m_act = 0, m_mode = 0, m_done = 0;
    int m_k = 0;
    pulse_stretcher_if bus();
    pulse_stretcher_if bus1();
    pulse_stretcher #(.DIV(DIV), .HOLD_TICKS(HT), .BLINK_HALF(BH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    pulse_stretcher #(.DIV(1), .HOLD_TICKS(1), .BLINK_HALF(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: a display is just "cycles since the trig edge"; blink phase follows from elapsed ticks
    function automatic logic exp_led();
        return m_act && (!m_mode || ((m_k / DIV) / BH) % 2 == 0);
    endfunction

    task automatic model_edge(input bit t, input bit b);
        if (!rst_n) begin
            m_act = 0; m_k = 0; m_done = 0;
        end else if (t && (!m_act || RETRIG)) begin
            m_act = 1; m_k = 0; m_mode = b; m_done = 0;
        end else if (m_act) begin
            m_k++;
            m_done = (m_k == T);
            if (m_done) m_act = 0;
        end else m_done = 0;
    endtask

    task automatic step(input bit t, input bit b, input string tag);
        bus.trig = t;
        bus.blink_mode = b;
        @(posedge clk);
        model_edge(t, b);
        @(negedge clk);
        check({tag, ".led"}, bus.led_out, exp_led());
        check({tag, ".busy"}, bus.busy, m_act);
        check({tag, ".done"}, bus.done, m_done);
    endtask

    initial begin
        vec_t tbl[14];
        vec_t t6[5];
        int busy_n, done_n, guard;
        bus.trig = 0; bus.blink_mode = 0;
        bus1.trig = 0; bus1.blink_mode = 0;
        tbl[0] = '{1, 1, 1, 1, 0};
        for (int i = 1; i < 12; i++) tbl[i] = '{0, 0, (i < 4 || i >= 8), 1, 0};
        tbl[12] = '{0, 0, 0, 0, 1};
        tbl[13] = '{0, 0, 0, 0, 0};
        t6[0] = '{1, 0, 1, 1, 0};
        t6[1] = '{0, 0, 0, 0, 1};
        t6[2] = '{1, 0, 1, 1, 0};
        t6[3] = '{0, 0, 0, 0, 1};
        t6[4] = '{0, 0, 0, 0, 0};
        repeat (2) @(negedge clk);
        check("rst.led", bus.led_out, 0);
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        check("rst1.busy", bus1.busy, 0);
        rst_n = 1'b1;
        step(0, 0, "idle");
        // solid display length and single done
        step(1, 0, "t1");
        busy_n = bus.busy; done_n = 0;
        for (int i = 0; i < 13; i++) begin
            step(0, 1, "t1");
            busy_n += bus.busy; done_n += bus.done;
        end
        check("t1.busy_len", busy_n, T);
        check("t1.done_cnt", done_n, 1);
        // blink pattern from a fixed table
        for (int i = 0; i < 14; i++) begin
            bus.trig = tbl[i].trig; bus.blink_mode = tbl[i].blink;
            @(posedge clk);
            model_edge(tbl[i].trig, tbl[i].blink);
            @(negedge clk);
            check($sformatf("t2[%0d].led", i), bus.led_out, tbl[i].led);
            check($sformatf("t2[%0d].busy", i), bus.busy, tbl[i].busy);
            check($sformatf("t2[%0d].done", i), bus.done, tbl[i].done);
        end
        // second trig five cycles into a display
        step(1, 0, "t3");
        busy_n = bus.busy; done_n = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, "t3"); busy_n += bus.busy; done_n += bus.done;
        end
        step(1, 1, "t3"); busy_n += bus.busy; done_n += bus.done;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, "t3"); busy_n += bus.busy; done_n += bus.done;
        end
        check("t3.busy_len", busy_n, RETRIG ? T + 5 : T);
        check("t3.done_cnt", done_n, 1);
        // trig landing on the terminating edge
        step(1, 0, "t4");
        guard = 0;
        while (m_k < T - 1 && guard < 20) begin
            step(0, 0, "t4"); guard++;
        end
        check("t4.reach_end", guard, T - 1);
        step(1, 0, "t4");
        check("t4.term_done", bus.done, RETRIG ? 0 : 1);
        check("t4.term_busy", bus.busy, RETRIG ? 1 : 0);
        busy_n = 0;
        for (int i = 0; i < 14; i++) begin
            step(0, 0, "t4"); busy_n += bus.busy;
        end
        check("t4.after_busy", busy_n, RETRIG ? T - 1 : 0);
        // async reset mid-display
        step(1, 1, "t5");
        for (int i = 0; i < 5; i++) step(0, 0, "t5");
        #2 rst_n = 1'b0;
        #1;
        check("t5.async_led", bus.led_out, 0);
        check("t5.async_busy", bus.busy, 0);
        check("t5.async_done", bus.done, 0);
        m_act = 0; m_done = 0; m_k = 0;
        step(0, 0, "t5rst");
        step(0, 0, "t5rst");
        rst_n = 1'b1;
        done_n = 0;
        for (int i = 0; i < 14; i++) begin
            step(0, 0, "t5idle"); done_n += bus.done;
        end
        check("t5.no_done", done_n, 0);
        step(1, 0, "t5re");
        busy_n = bus.busy;
        for (int i = 0; i < 13; i++) begin
            step(0, 0, "t5re"); busy_n += bus.busy;
        end
        check("t5.busy_len", busy_n, T);
        // random traffic
        for (int i = 0; i < 400; i++) step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), "rnd");
        // DIV=1, HOLD_TICKS=1 instance
        bus.trig = 0;
        for (int i = 0; i < 5; i++) begin
            bus1.trig = t6[i].trig; bus1.blink_mode = t6[i].blink;
            @(posedge clk);
            model_edge(0, 0);
            @(negedge clk);
            check($sformatf("t6[%0d].led", i), bus1.led_out, t6[i].led);
            check($sformatf("t6[%0d].busy", i), bus1.busy, t6[i].busy);
            check($sformatf("t6[%0d].done", i), bus1.done, t6[i].done);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
